// File: rtl/salu_instr_pkg.sv
// Shared instruction-word constants and fetch address type for the SALU front end.
package salu_instr_pkg;

    localparam int unsigned INSTR_SIZE   = 32;
    localparam int unsigned INSTR_BYTES  = INSTR_SIZE / 8;
    localparam int unsigned FETCH_ADDR_W = 32;

    typedef logic [FETCH_ADDR_W-1:0] fetch_addr_t;
    typedef logic [INSTR_SIZE-1:0]   instr_word_t;

endpackage : salu_instr_pkg

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, registered storage and same-cycle push/pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Full pushes and empty pops are ignored so the pointers never cross.
    assign do_push  = push && !flush && (count_q != CNT_W'(DEPTH));
    assign do_pop   = pop  && !flush && (count_q != '0);
    assign pop_data = mem[rd_ptr_q];
    assign count    = count_q;

    // Next pointer and occupancy; flush empties the buffer in one cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule : sync_fifo

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetcher: PC, credit-limited icache requests, buffered
// instruction stream, and redirect with exact discard of stale responses.
module instr_fetch_unit
    import salu_instr_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(32'h0000_0100)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic                   resp_valid,
    output logic                   resp_ready,
    input  logic [INSTR_SIZE-1:0]  resp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_SIZE-1:0]  instr_data
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [CNT_W-1:0]      discard_q, discard_d;
    logic [CNT_W-1:0]      fifo_count;
    logic                  credit_ok;
    logic                  req_fire;
    logic                  resp_fire;
    logic                  fifo_push;
    logic                  fifo_pop;

    // Outstanding requests plus buffered words may never exceed the buffer size,
    // so every response has a slot waiting for it.
    assign credit_ok  = ({1'b0, inflight_q} + {1'b0, fifo_count}) < SUM_W'(FIFO_DEPTH);
    assign req_valid  = rst_n && enable && !redirect_valid && credit_ok;
    assign req_addr   = pc_q;
    assign req_fire   = req_valid && req_ready;
    assign resp_ready = 1'b1;
    assign resp_fire  = resp_valid;

    // Stale responses (discard pending, or arriving in a redirect cycle) never reach the buffer.
    assign fifo_push   = resp_fire && (discard_q == '0) && !redirect_valid;
    assign instr_valid = rst_n && (fifo_count != '0) && !redirect_valid;
    assign fifo_pop    = instr_valid && instr_ready;

    // Instruction buffer; a redirect flushes it.
    sync_fifo #(
        .WIDTH (INSTR_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (resp_data),
        .pop       (fifo_pop),
        .pop_data  (instr_data),
        .count     (fifo_count)
    );

    // Next PC, in-flight and discard counters.
    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;

        if (req_fire) begin
            pc_d = pc_q + ADDR_WIDTH'(INSTR_BYTES);
        end

        case ({req_fire, resp_fire})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        // Everything still outstanding after this cycle predates the redirect;
        // inflight already includes requests whose discard was pending.
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            discard_d = inflight_q - CNT_W'(resp_fire);
        end else if (resp_fire && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a simple in-order icache model.
module tb_instr_fetch_unit;
    import salu_instr_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               redirect_valid;
    fetch_addr_t        redirect_pc;
    logic               req_valid;
    logic               req_ready;
    fetch_addr_t        req_addr;
    logic               resp_valid;
    logic               resp_ready;
    instr_word_t        resp_data;
    logic               instr_valid;
    logic               instr_ready;
    instr_word_t        instr_data;

    int                 checks;
    int                 failures;
    int                 overflow_errs;
    bit                 icache_hold;
    fetch_addr_t        pend[$];
    fetch_addr_t        reqs[$];
    instr_word_t        got[$];

    instr_fetch_unit #(
        .ADDR_WIDTH (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (32'h0000_0100)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // icache content: tag in the upper half, low address bits below.
    function automatic instr_word_t word_of(input fetch_addr_t a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // One clock: icache presents in order, requests/instructions recorded at negedge.
    task automatic cycle();
        if (!resp_valid && !icache_hold && pend.size() > 0) begin
            resp_data  = word_of(pend.pop_front());
            resp_valid = 1'b1;
        end
        @(negedge clk);
        if (rst_n && req_valid && req_ready) begin
            pend.push_back(req_addr);
            reqs.push_back(req_addr);
        end
        if (rst_n && instr_valid && instr_ready) got.push_back(instr_data);
        if (rst_n && dut.fifo_push && !dut.fifo_pop && dut.fifo_count == 3'd4) overflow_errs++;
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
        if (!icache_hold && pend.size() > 0) begin
            resp_data  = word_of(pend.pop_front());
            resp_valid = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        enable         = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        req_ready      = 1'b1;
        resp_valid     = 1'b0;
        resp_data      = '0;
        instr_ready    = 1'b1;
        icache_hold    = 1'b0;
        pend.delete();
        reqs.delete();
        got.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (req_valid !== 1'b0) begin
            failures++; $display("FAIL reset_req_valid: got %b expected 0", req_valid);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid);
        end
        checks++;
        if (resp_ready !== 1'b1) begin
            failures++; $display("FAIL reset_resp_ready: got %b expected 1", resp_ready);
        end
        checks++;
        if (req_addr !== 32'h0000_0100) begin
            failures++; $display("FAIL reset_pc: got %h expected 00000100", req_addr);
        end
        do_reset();
        checks++;
        if (req_valid !== 1'b1) begin
            failures++; $display("FAIL reset_release_req_valid: got %b expected 1", req_valid);
        end
    endtask

    task automatic test_stream();
        fetch_addr_t exp_a[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        instr_word_t exp_w[4] = '{32'hC0DE_0100, 32'hC0DE_0104, 32'hC0DE_0108, 32'hC0DE_010C};
        do_reset();
        repeat (8) cycle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (reqs.size() <= i || reqs[i] !== exp_a[i]) begin
                failures++;
                $display("FAIL stream_req_addr[%0d]: got %h expected %h", i,
                         (reqs.size() > i) ? reqs[i] : 32'hDEAD_DEAD, exp_a[i]);
            end
            checks++;
            if (got.size() <= i || got[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL stream_instr[%0d]: got %h expected %h", i,
                         (got.size() > i) ? got[i] : 32'hDEAD_DEAD, exp_w[i]);
            end
        end
        // Reset while busy drops all state.
        do_reset();
        checks++;
        if (dut.fifo_count !== 3'd0 || dut.inflight_q !== 3'd0 || dut.discard_q !== 3'd0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset: fifo=%0d inflight=%0d discard=%0d ivalid=%b expected 0 0 0 0",
                     dut.fifo_count, dut.inflight_q, dut.discard_q, instr_valid);
        end
    endtask

    task automatic test_backpressure();
        fetch_addr_t exp_a[5] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
        instr_word_t exp_w[5] = '{32'hC0DE_0100, 32'hC0DE_0104, 32'hC0DE_0108, 32'hC0DE_010C, 32'hC0DE_0110};
        do_reset();
        instr_ready = 1'b0;
        repeat (10) cycle();
        checks++;
        if (reqs.size() != 4) begin
            failures++; $display("FAIL bp_req_count: got %0d expected 4", reqs.size());
        end
        checks++;
        if (dut.fifo_count !== 3'd4) begin
            failures++; $display("FAIL bp_fifo_count: got %0d expected 4", dut.fifo_count);
        end
        checks++;
        if (req_valid !== 1'b0) begin
            failures++; $display("FAIL bp_req_valid: got %b expected 0", req_valid);
        end
        instr_ready = 1'b1;
        repeat (8) cycle();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL bp_drain[%0d]: got %h expected %h", i,
                         (got.size() > i) ? got[i] : 32'hDEAD_DEAD, exp_w[i]);
            end
        end
        checks++;
        if (reqs.size() <= 4 || reqs[4] !== exp_a[4]) begin
            failures++;
            $display("FAIL bp_resume_addr: got %h expected %h",
                     (reqs.size() > 4) ? reqs[4] : 32'hDEAD_DEAD, exp_a[4]);
        end
    endtask

    task automatic test_redirect_discard();
        do_reset();
        icache_hold = 1'b1;
        repeat (3) cycle();
        checks++;
        if (dut.inflight_q !== 3'd3) begin
            failures++; $display("FAIL rd_inflight: got %0d expected 3", dut.inflight_q);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (dut.discard_q !== 3'd3) begin
            failures++; $display("FAIL rd_discard: got %0d expected 3", dut.discard_q);
        end
        checks++;
        if (reqs.size() != 3) begin
            failures++; $display("FAIL rd_no_req_in_redirect: got %0d expected 3", reqs.size());
        end
        icache_hold = 1'b0;
        repeat (10) cycle();
        checks++;
        if (reqs.size() <= 3 || reqs[3] !== 32'h200) begin
            failures++;
            $display("FAIL rd_first_addr: got %h expected 00000200",
                     (reqs.size() > 3) ? reqs[3] : 32'hDEAD_DEAD);
        end
        checks++;
        if (got.size() == 0 || got[0] !== 32'hC0DE_0200) begin
            failures++;
            $display("FAIL rd_first_word: got %h expected c0de0200",
                     (got.size() > 0) ? got[0] : 32'hDEAD_DEAD);
        end
        checks++;
        if (dut.discard_q !== 3'd0) begin
            failures++; $display("FAIL rd_discard_done: got %0d expected 0", dut.discard_q);
        end
    endtask

    task automatic test_redirect_with_resp();
        do_reset();
        instr_ready = 1'b0;
        repeat (2) cycle();
        icache_hold = 1'b1;
        repeat (2) cycle();
        checks++;
        if (dut.fifo_count !== 3'd2 || dut.inflight_q !== 3'd2) begin
            failures++;
            $display("FAIL rr_setup: fifo=%0d inflight=%0d expected 2 2", dut.fifo_count, dut.inflight_q);
        end
        icache_hold    = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        cycle();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (dut.fifo_count !== 3'd0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_flush: fifo=%0d ivalid=%b expected 0 0", dut.fifo_count, instr_valid);
        end
        checks++;
        if (dut.discard_q !== 3'd1 || dut.inflight_q !== 3'd1) begin
            failures++;
            $display("FAIL rr_discard: discard=%0d inflight=%0d expected 1 1", dut.discard_q, dut.inflight_q);
        end
        checks++;
        if (got.size() != 0) begin
            failures++; $display("FAIL rr_no_delivery: got %0d words expected 0", got.size());
        end
        repeat (8) cycle();
        checks++;
        if (got.size() == 0 || got[0] !== 32'hC0DE_0300) begin
            failures++;
            $display("FAIL rr_first_word: got %h expected c0de0300",
                     (got.size() > 0) ? got[0] : 32'hDEAD_DEAD);
        end
        checks++;
        if (reqs.size() <= 4 || reqs[4] !== 32'h300) begin
            failures++;
            $display("FAIL rr_first_addr: got %h expected 00000300",
                     (reqs.size() > 4) ? reqs[4] : 32'hDEAD_DEAD);
        end
    endtask

    task automatic test_stall_enable();
        do_reset();
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (req_valid !== 1'b1 || req_addr !== 32'h100) begin
                failures++;
                $display("FAIL stall_hold[%0d]: valid=%b addr=%h expected 1 00000100", i, req_valid, req_addr);
            end
        end
        req_ready   = 1'b1;
        instr_ready = 1'b0;
        repeat (3) cycle();
        enable      = 1'b0;
        instr_ready = 1'b1;
        repeat (6) cycle();
        checks++;
        if (reqs.size() != 3 || req_valid !== 1'b0 || req_addr !== 32'h10C) begin
            failures++;
            $display("FAIL en_low_no_req: n=%0d valid=%b addr=%h expected 3 0 0000010c",
                     reqs.size(), req_valid, req_addr);
        end
        checks++;
        if (got.size() != 3 || got[0] !== 32'hC0DE_0100 || got[2] !== 32'hC0DE_0108) begin
            failures++;
            $display("FAIL en_low_drain: n=%0d first=%h last=%h expected 3 c0de0100 c0de0108",
                     got.size(), (got.size() > 0) ? got[0] : 32'hDEAD_DEAD,
                     (got.size() > 2) ? got[2] : 32'hDEAD_DEAD);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        repeat (6) cycle();
        checks++;
        if (reqs.size() < 2 || reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0000_0000) begin
            failures++;
            $display("FAIL wrap_addr: got %h %h expected fffffffc 00000000",
                     (reqs.size() > 0) ? reqs[0] : 32'hDEAD_DEAD,
                     (reqs.size() > 1) ? reqs[1] : 32'hDEAD_DEAD);
        end
        checks++;
        if (got.size() < 2 || got[0] !== 32'hC0DE_FFFC || got[1] !== 32'hC0DE_0000) begin
            failures++;
            $display("FAIL wrap_words: got %h %h expected c0defffc c0de0000",
                     (got.size() > 0) ? got[0] : 32'hDEAD_DEAD,
                     (got.size() > 1) ? got[1] : 32'hDEAD_DEAD);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        overflow_errs  = 0;
        rst_n          = 1'b0;
        enable         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        req_ready      = 1'b1;
        resp_valid     = 1'b0;
        resp_data      = '0;
        instr_ready    = 1'b1;
        icache_hold    = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_discard();
        test_redirect_with_resp();
        test_stall_enable();
        test_wrap();

        checks++;
        if (overflow_errs != 0) begin
            failures++; $display("FAIL fifo_overflow: got %0d events expected 0", overflow_errs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_instr_fetch_unit
